alu_rr_arbiter: RTL
===================

# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one `alu_4bit` instance between two independent requesters. Each requester issues operations over a valid/ready request channel and receives results over a valid/ready response channel. The block latches operands, holds the ALU inputs stable for a fixed execute window, registers the result, and returns it only to the granted requester. It sits between the two operand-producing front ends and the combinational ALU datapath.

## Interface
- `MUL_CYCLES`, default 2: number of execute cycles for TT=2'b10 (MUL); legal range 1..7. All other operations use 1 execute cycle.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid_0`, `req_valid_1` input 1: request pending from requester 0 or 1.
- `req_ready_0`, `req_ready_1` output 1: request accepted this cycle.
- `req_a_0`, `req_a_1` input 4: operand A.
- `req_b_0`, `req_b_1` input 4: operand B.
- `req_tt_0`, `req_tt_1` input 2: opcode. 00 ADD, 01 SUB, 10 MUL, 11 AND.
- `rsp_valid_0`, `rsp_valid_1` output 1: result available for requester 0 or 1.
- `rsp_ready_0`, `rsp_ready_1` input 1: requester consumes the result.
- `rsp_result` output 8: registered ALU Result. Shared bus; meaningful only while some `rsp_valid_x` is high.
- `rsp_cout` output 1: registered ALU cout.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: reset state.
  - EXEC: the ALU is driven from the operand registers.
  - RESP: a result is held for the granted requester.
- IDLE:
  - Grant is computed combinationally from the two valid inputs and the priority pointer `prio`.
  - If exactly one `req_valid` is high, that requester wins.
  - If both are high, requester `prio` wins.
  - `req_ready_g` is high only in IDLE, only for the winner, and only when its `req_valid` is high.
  - On acceptance, the block registers A, B and TT. It stores the grant index `g`. It loads the execute counter with `MUL_CYCLES-1` for MUL and with 0 otherwise. It sets `prio` to `~g`. The state then moves to EXEC.
  - If no request is valid, the block stays in IDLE and `prio` is unchanged.
- EXEC:
  - The ALU inputs come only from the operand registers, never from the live request inputs.
  - A nonzero counter decrements each cycle.
  - When the counter is 0, the block captures ALU Result and cout into `rsp_result` and `rsp_cout`, and the state moves to RESP.
- RESP:
  - `rsp_valid_g` is high; the other `rsp_valid` is low.
  - `rsp_result` and `rsp_cout` are held stable.
  - When `rsp_ready_g` is high, the state moves to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- Both `req_ready` outputs are low in EXEC and RESP. New requests wait and are not dropped.
- Requester inputs are sampled only at the accept edge. Changes to A, B or TT after acceptance have no effect on the current operation.
- Arithmetic is the `alu_4bit` definition:
  - ADD and SUB: 4-bit result in `Result[3:0]`, upper nibble zero, carry in cout. SUB is A+~B+1.
  - MUL: full 8-bit product, cout=0.
  - AND: 4-bit result, cout=0.
- Reset (asynchronous, any time) forces:
  - state=IDLE, `prio`=0, counter=0;
  - `rsp_result`=8'h00, `rsp_cout`=0;
  - all `req_ready` and `rsp_valid` low, `busy`=0.
  - An in-flight operation is discarded and never answered.

## Timing
- Cycle 0 is the accept cycle (the valid/ready handshake completes at the end of cycle 0).
- EXEC occupies cycles 1..k, with k=1 for non-MUL and k=`MUL_CYCLES` for MUL.
- `rsp_valid_g` rises in cycle k+1. That is cycle 2 for ADD/SUB/AND, and cycle 3 for MUL with the default parameter.
- If `rsp_ready_g` is high in the first RESP cycle, the block is in IDLE the next cycle and can accept again.
- Minimum issue interval is k+2 cycles.
- Back-pressure: RESP lasts indefinitely while `rsp_ready_g` is low.
- Fairness: when both requesters are continuously valid, grants alternate 0,1,0,1,…, starting with 0 after reset.
- `req_ready` depends combinationally on `req_valid` and state only. It never depends on `rsp_ready`.

## Test plan
- ADD, requester 0 only: A=7, B=9, TT=00 accepted in cycle 0 -> `rsp_valid_0` high in cycle 2, `rsp_result`=8'h00, `rsp_cout`=1, `rsp_valid_1` stays low.
- SUB then AND, requester 1, `rsp_ready_1` tied high:
  - A=3, B=5, TT=01 -> `rsp_result`=8'h0E, `rsp_cout`=0.
  - Next request accepted in the cycle after RESP, A=C, B=A, TT=11 -> 8'h08, `rsp_cout`=0.
- MUL latency and operand isolation: A=F, B=F, TT=10, with A/B/TT changed to 0 in cycle 1 -> `rsp_valid_0` in cycle 3, `rsp_result`=8'hE1, `rsp_cout`=0.
- Contention after reset: both valid continuously with distinct operands -> accept order is 0,1,0,1. Each result appears only on the matching `rsp_valid`, and no `req_ready` is seen during EXEC or RESP.
- Back-pressure: hold `rsp_ready_0` low for 5 RESP cycles while `req_valid_1` is high -> result, `rsp_cout` and `rsp_valid_0` stay stable, `req_ready_1` stays low. Requester 1 is accepted in the cycle after the RESP handshake.
- Reset mid-operation: assert `rst` asynchronously during EXEC of a MUL -> all outputs immediately at reset values. After release, no stale `rsp_valid` appears, and the first contended grant goes to requester 0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester round-robin sequencer around a shared 4-bit ALU
//
// alu_4bit: combinational ALU.
//   a_i, b_i [3:0]   operands
//   tt_i     [1:0]   opcode: 00 ADD, 01 SUB (A+~B+1), 10 MUL, 11 AND
//   result_o [7:0]   ADD/SUB/AND in low nibble (upper nibble zero), MUL full product
//   cout_o           carry out of ADD/SUB, zero otherwise
//
// alu_rr_arbiter: grants one of two requesters, executes on alu_4bit, returns the result.
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid_x / req_ready_x      request handshake per requester (x = 0, 1)
//   req_a_x, req_b_x, req_tt_x     request operands and opcode
//   rsp_valid_x / rsp_ready_x      response handshake per requester
//   rsp_result [7:0], rsp_cout     registered result, shared by both requesters
//   busy                           high whenever not idle

module alu_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic [1:0] tt_i,
   output logic [7:0] result_o,
   output logic       cout_o
);
   logic [4:0] sum5;
   logic [4:0] diff5;

   always_comb begin
      sum5     = {1'b0, a_i} + {1'b0, b_i};
      diff5    = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
      result_o = 8'h00;
      cout_o   = 1'b0;
      case (tt_i)
         2'b00: begin
            result_o = {4'h0, sum5[3:0]};
            cout_o   = sum5[4];
         end
         2'b01: begin
            result_o = {4'h0, diff5[3:0]};
            cout_o   = diff5[4];
         end
         2'b10: result_o = {4'h0, a_i} * {4'h0, b_i};
         default: result_o = {4'h0, a_i & b_i};
      endcase
   end
endmodule

module alu_rr_arbiter #(
   parameter int MUL_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid_0,
   input  logic       req_valid_1,
   output logic       req_ready_0,
   output logic       req_ready_1,
   input  logic [3:0] req_a_0,
   input  logic [3:0] req_a_1,
   input  logic [3:0] req_b_0,
   input  logic [3:0] req_b_1,
   input  logic [1:0] req_tt_0,
   input  logic [1:0] req_tt_1,
   output logic       rsp_valid_0,
   output logic       rsp_valid_1,
   input  logic       rsp_ready_0,
   input  logic       rsp_ready_1,
   output logic [7:0] rsp_result,
   output logic       rsp_cout,
   output logic       busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // MUL holds the execute window for MUL_CYCLES cycles: counter runs MUL_CYCLES-1 .. 0.
   localparam logic [2:0] MUL_LOAD = 3'(MUL_CYCLES - 1);

   state_t     state_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [1:0] tt_q;
   logic       g_q;
   logic       prio_q;
   logic [2:0] cnt_q;
   logic [7:0] result_q;
   logic       cout_q;

   logic       win_d;
   logic       accept_d;
   logic [3:0] sel_a_d;
   logic [3:0] sel_b_d;
   logic [1:0] sel_tt_d;
   logic       sel_rsp_ready_d;
   logic [7:0] alu_result;
   logic       alu_cout;

   always_comb begin
      // A lone requester wins outright; under contention the pointer decides.
      win_d    = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
      // Gated by rst so both readies read low for the whole reset assertion.
      accept_d = (state_q == IDLE) && (req_valid_0 || req_valid_1) && !rst;
      sel_a_d  = win_d ? req_a_1 : req_a_0;
      sel_b_d  = win_d ? req_b_1 : req_b_0;
      sel_tt_d = win_d ? req_tt_1 : req_tt_0;
      sel_rsp_ready_d = g_q ? rsp_ready_1 : rsp_ready_0;
   end

   assign req_ready_0 = accept_d && !win_d;
   assign req_ready_1 = accept_d && win_d;
   assign rsp_valid_0 = (state_q == RESP) && !g_q;
   assign rsp_valid_1 = (state_q == RESP) && g_q;
   assign rsp_result  = result_q;
   assign rsp_cout    = cout_q;
   assign busy        = (state_q != IDLE);

   // ALU sees only the latched operands, so requester changes after accept are invisible.
   alu_4bit u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .tt_i     (tt_q),
      .result_o (alu_result),
      .cout_o   (alu_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= 4'h0;
         b_q      <= 4'h0;
         tt_q     <= 2'b00;
         g_q      <= 1'b0;
         prio_q   <= 1'b0;
         cnt_q    <= 3'd0;
         result_q <= 8'h00;
         cout_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  a_q     <= sel_a_d;
                  b_q     <= sel_b_d;
                  tt_q    <= sel_tt_d;
                  g_q     <= win_d;
                  prio_q  <= ~win_d;
                  cnt_q   <= (sel_tt_d == 2'b10) ? MUL_LOAD : 3'd0;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q != 3'd0) begin
                  cnt_q <= cnt_q - 3'd1;
               end else begin
                  result_q <= alu_result;
                  cout_q   <= alu_cout;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               if (sel_rsp_ready_d) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
